// File: rtl/fdiv.sv
// -----------------------------------------------------------------------------
// fdiv -- multi-cycle IEEE-754 single-precision divider.
//
// A divide is accepted while idle, then either resolves in one cycle (special
// operands: NaN, infinity, zero) or runs a 25-step restoring division of the
// significands followed by one normalisation cycle. Denormal inputs are
// flushed to zero and rounding is truncation.
//
// Ports:
//   CLK       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Start     in   start request, sampled only while Busy=0
//   Operand1  in   [31:0] dividend
//   Operand2  in   [31:0] divisor
//   WA3       in   [3:0]  destination tag, captured with the operands
//   Result    out  [31:0] quotient, updated only when Busy falls
//   Busy      out  high while a divide is in flight
//   Done      out  one-cycle pulse marking a new Result
//   FDIVWA3   out  [3:0]  tag of the in-flight or last completed divide
// -----------------------------------------------------------------------------
module fdiv (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic [3:0]  WA3,
  output logic [31:0] Result,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  FDIVWA3
);

  typedef enum logic [1:0] {IDLE, SPEC, DIV, NORM} state_t;

  // Outcome of operand classification; K_NORMAL means a real division is needed.
  typedef enum logic [1:0] {K_NORMAL, K_NAN, K_INF, K_ZERO} kind_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Classify a pair of operands (sign bits are irrelevant here).
  // Exponent 0 counts as zero regardless of fraction (denormals flushed).
  function automatic kind_t classify(input logic [30:0] a, input logic [30:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      classify = K_NAN;
    else if (b_zero || a_inf)
      classify = K_INF;
    else if (a_zero || b_inf)
      classify = K_ZERO;
    else
      classify = K_NORMAL;
  endfunction

  state_t       state_q, state_d;
  logic [31:0]  op1_q, op1_d;
  logic [31:0]  op2_q, op2_d;
  logic [3:0]   tag_q, tag_d;
  logic [24:0]  quo_q, quo_d;
  logic [25:0]  rem_q, rem_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  result_q, result_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic        res_sign;
  kind_t       spec_kind;
  logic [25:0] divisor_ext;
  logic        rem_ge;
  logic [25:0] rem_sub;
  logic [25:0] rem_kept;
  logic signed [9:0] exp_n;
  logic [22:0] man_n;
  logic [31:0] norm_result;
  logic [31:0] spec_result;

  assign res_sign    = op1_q[31] ^ op2_q[31];
  assign spec_kind   = classify(op1_q[30:0], op2_q[30:0]);

  // One restoring step: subtract the divisor if it fits, then shift left.
  // The remainder stays below twice the divisor, so 26 bits never overflow.
  assign divisor_ext = {2'b00, 1'b1, op2_q[22:0]};
  assign rem_ge      = (rem_q >= divisor_ext);
  assign rem_sub     = rem_q - divisor_ext;
  assign rem_kept    = rem_ge ? rem_sub : rem_q;

  // Quotient lies in (0.5, 2): bit 24 set means it is already in [1, 2).
  assign exp_n = {2'b00, op1_q[30:23]} - {2'b00, op2_q[30:23]}
               + (quo_q[24] ? 10'd127 : 10'd126);
  assign man_n = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

  always_comb begin
    if (exp_n >= 10'sd255)
      norm_result = {res_sign, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)
      norm_result = {res_sign, 31'd0};
    else
      norm_result = {res_sign, exp_n[7:0], man_n};
  end

  always_comb begin
    case (spec_kind)
      K_NAN:   spec_result = QNAN;
      K_INF:   spec_result = {res_sign, 8'hFF, 23'd0};
      default: spec_result = {res_sign, 31'd0};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    tag_d    = tag_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          op1_d  = Operand1;
          op2_d  = Operand2;
          tag_d  = WA3;
          busy_d = 1'b1;
          quo_d  = '0;
          cnt_d  = '0;
          rem_d  = {2'b00, 1'b1, Operand1[22:0]};
          state_d = (classify(Operand1[30:0], Operand2[30:0]) == K_NORMAL) ? DIV : SPEC;
        end
      end
      SPEC: begin
        result_d = spec_result;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      DIV: begin
        quo_d = {quo_q[23:0], rem_ge};
        rem_d = rem_kept << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24)
          state_d = NORM;
      end
      NORM: begin
        result_d = norm_result;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      tag_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      tag_q    <= tag_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Result  = result_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign FDIVWA3 = tag_q;

endmodule

// File: tb/tb_fdiv.sv
// -----------------------------------------------------------------------------
// tb_fdiv -- self-checking bench for fdiv.
//
// A behavioural model (integer division of the significands plus the IEEE
// special-case rules, and a countdown for latency) predicts Busy, Done, Result
// and FDIVWA3 every cycle; a compare process checks them on each falling edge.
// Directed vectors additionally carry hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_fdiv;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [3:0]  WA3 = '0;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic [3:0]  FDIVWA3;

  fdiv dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .WA3      (WA3),
    .Result   (Result),
    .Busy     (Busy),
    .Done     (Done),
    .FDIVWA3  (FDIVWA3)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    bit a_zero = (ea == 0);
    bit b_zero = (eb == 0);
    bit a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    bit b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    bit a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    bit b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    logic s    = a[31] ^ b[31];
    longint na, nb, q;
    int e;
    logic [22:0] man;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 32'h7FC0_0000;
    if (b_zero || a_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_inf) return {s, 31'd0};
    na = 64'h80_0000 | longint'(a[22:0]);
    nb = 64'h80_0000 | longint'(b[22:0]);
    q  = (na << 24) / nb;
    if (q >= 64'h100_0000) begin
      e   = ea - eb + 127;
      man = 23'((q >> 1) & 64'h7F_FFFF);
    end else begin
      e   = ea - eb + 126;
      man = 23'(q & 64'h7F_FFFF);
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), man};
  endfunction

  // Cycle-level expectations: cycles left in flight, pending and visible result.
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;
  logic        m_done = 1'b0;
  logic [3:0]  m_tag = '0;

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      m_left   = 0;
      m_pend   = '0;
      m_result = '0;
      m_done   = 1'b0;
      m_tag    = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_result = m_pend;
        m_done   = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (Start) begin
        m_pend = ref_div(Operand1, Operand2);
        m_left = ref_special(Operand1, Operand2) ? 1 : 26;
        m_tag  = WA3;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cyc_busy",   {31'd0, Busy}, (m_left > 0) ? 32'd1 : 32'd0);
      check("cyc_done",   {31'd0, Done}, {31'd0, m_done});
      check("cyc_result", Result, m_result);
      check("cyc_tag",    {28'd0, FDIVWA3}, {28'd0, m_tag});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed transaction: entered and left at a falling edge. Leaving on the
  // Done cycle lets the next call start back-to-back.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] lit, input int lat, input bit intrude);
    int busy_n = 0;
    int guard  = 0;
    check("model_pin", ref_div(a, b), lit);
    Operand1 = a;
    Operand2 = b;
    WA3      = tag;
    Start    = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    while (!Done && guard < 60) begin
      if (intrude && busy_n == 10) begin
        Start    = 1'b1;
        Operand1 = 32'h3F80_0000;
        Operand2 = 32'h4000_0000;
        WA3      = ~tag;
      end else begin
        Start = 1'b0;
      end
      if (Busy) busy_n++;
      guard++;
      @(negedge CLK);
    end
    Start = 1'b0;
    check("done_seen",  {31'd0, Done}, 32'd1);
    check("latency",    32'(busy_n), 32'(lat));
    check("result_lit", Result, lit);
    check("tag_lit",    {28'd0, FDIVWA3}, {28'd0, tag});
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    #1 Reset_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_result", Result, 32'd0);
    check("rst_busy",   {31'd0, Busy}, 32'd0);
    check("rst_done",   {31'd0, Done}, 32'd0);
    check("rst_tag",    {28'd0, FDIVWA3}, 32'd0);

    // Start on the very first edge after reset release.
    Reset_n = 1'b1;
    run_op(32'h40C0_0000, 32'h4000_0000, 4'd5,  32'h4040_0000, 26, 1'b0); // 6/2
    run_op(32'h3F80_0000, 32'h4040_0000, 4'd1,  32'h3EAA_AAAA, 26, 1'b0); // 1/3 truncated
    run_op(32'hBF80_0000, 32'h0000_0000, 4'd2,  32'hFF80_0000, 1,  1'b0); // -1/0
    run_op(32'h0000_0000, 32'h0000_0000, 4'd3,  32'h7FC0_0000, 1,  1'b0); // 0/0
    run_op(32'h7F00_0000, 32'h0080_0000, 4'd4,  32'h7F80_0000, 26, 1'b0); // overflow
    run_op(32'h0080_0000, 32'h7F00_0000, 4'd6,  32'h0000_0000, 26, 1'b0); // underflow
    run_op(32'h7FC1_2345, 32'h3F80_0000, 4'd7,  32'h7FC0_0000, 1,  1'b0); // NaN in
    run_op(32'h7F80_0000, 32'hFF80_0000, 4'd8,  32'h7FC0_0000, 1,  1'b0); // inf/inf
    run_op(32'h4000_0000, 32'hFF80_0000, 4'd9,  32'h8000_0000, 1,  1'b0); // 2/-inf
    run_op(32'h7F80_0000, 32'hC000_0000, 4'd10, 32'hFF80_0000, 1,  1'b0); // inf/-2
    run_op(32'h0040_0000, 32'h3F80_0000, 4'd11, 32'h0000_0000, 1,  1'b0); // denormal/1
    run_op(32'hC0F0_0000, 32'h4020_0000, 4'd12, 32'hC040_0000, 26, 1'b0); // -7.5/2.5
    run_op(32'h3F80_0000, 32'h3F80_0000, 4'd13, 32'h3F80_0000, 26, 1'b0); // 1/1
    // Second Start mid-divide must be ignored.
    run_op(32'h40C0_0000, 32'h4000_0000, 4'd14, 32'h4040_0000, 26, 1'b1);

    // Reset in the middle of a divide.
    Operand1 = 32'h3F80_0000;
    Operand2 = 32'h4040_0000;
    WA3      = 4'd15;
    Start    = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (11) @(negedge CLK);
    check("mid_busy", {31'd0, Busy}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, Busy}, 32'd0);
    check("arst_done",   {31'd0, Done}, 32'd0);
    check("arst_result", Result, 32'd0);
    check("arst_tag",    {28'd0, FDIVWA3}, 32'd0);
    @(negedge CLK);
    Reset_n  = 1'b1;
    done_cnt = 0;
    repeat (32) begin
      @(negedge CLK);
      if (Done) done_cnt++;
    end
    check("no_done_after_reset", 32'(done_cnt), 32'd0);

    run_op(32'h3F80_0000, 32'h4040_0000, 4'd3, 32'h3EAA_AAAA, 26, 1'b0);
    @(negedge CLK);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
